// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - Instruction fetch stage: PC ownership, imem handshake, instruction field split
module instr_fetch #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      pcsrc,
   input  logic [XLEN-1:0] immext,
   input  logic [XLEN-1:0] aluresult,
   input  logic            commit,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rdy,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pcplus4,
   output logic [31:0]     instr,
   output logic [6:0]      opc,
   output logic [2:0]      f3,
   output logic [6:0]      f7,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic            instr_valid,
   output logic            err
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_TRAP  = 2'd2
   } state_t;

   state_t          state_q;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     instr_q;
   logic            err_q;
   logic            req_q;
   logic            valid_q;

   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] jalr_tgt;
   logic            misaligned;

   // jalr target has bit 0 cleared; the remaining low bit is what traps
   assign jalr_tgt = aluresult & ~XLEN'(1);

   // Next-PC select; reserved encoding behaves like sequential fetch
   always_comb begin
      pc_d = pc_q + XLEN'(4);
      case (pcsrc)
         2'b01:   pc_d = pc_q + immext;
         2'b10:   pc_d = jalr_tgt;
         default: pc_d = pc_q + XLEN'(4);
      endcase
   end

   assign misaligned = (pc_d[1:0] != 2'b00);

   // Fetch/execute/trap sequencer with registered request and valid flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         err_q   <= 1'b0;
         req_q   <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem_rdy) begin
                  instr_q <= imem_rdata;
                  state_q <= S_EXEC;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            S_EXEC: begin
               if (commit) begin
                  valid_q <= 1'b0;
                  if (misaligned) begin
                     err_q   <= 1'b1;
                     req_q   <= 1'b0;
                     state_q <= S_TRAP;
                  end else begin
                     pc_q    <= pc_d;
                     req_q   <= 1'b1;
                     state_q <= S_FETCH;
                  end
               end
            end
            S_TRAP: begin
               err_q   <= 1'b1;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
            default: begin
               state_q <= S_FETCH;
               req_q   <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Request is suppressed combinationally while reset is held
   assign imem_req    = req_q & ~rst;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign pcplus4     = pc_q + XLEN'(4);
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign err         = err_q;

   assign opc = instr_q[6:0];
   assign f3  = instr_q[14:12];
   assign f7  = instr_q[31:25];
   assign rs1 = instr_q[19:15];
   assign rs2 = instr_q[24:20];
   assign rd  = instr_q[11:7];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - Directed self-checking bench for instr_fetch
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic [1:0]  pcsrc;
   logic [31:0] immext;
   logic [31:0] aluresult;
   logic        commit;
   logic        imem_rdy;
   logic [31:0] imem_rdata;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] pcplus4;
   logic [31:0] instr;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        instr_valid;
   logic        err;

   // second instance for the address wrap case
   logic        w_rst;
   logic        w_commit;
   logic        w_rdy;
   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_pc;
   logic [31:0] w_pcplus4;
   logic [31:0] w_instr;
   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rd;
   logic        w_valid;
   logic        w_err;

   int tests;
   int fails;

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .pcsrc(pcsrc), .immext(immext), .aluresult(aluresult),
      .commit(commit), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
      .imem_rdata(imem_rdata), .pc(pc), .pcplus4(pcplus4), .instr(instr), .opc(opc),
      .f3(f3), .f7(f7), .rs1(rs1), .rs2(rs2), .rd(rd), .instr_valid(instr_valid), .err(err)
   );

   instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(w_rst), .pcsrc(2'b00), .immext(32'h0), .aluresult(32'h0),
      .commit(w_commit), .imem_req(w_req), .imem_addr(w_addr), .imem_rdy(w_rdy),
      .imem_rdata(32'h0000_0013), .pc(w_pc), .pcplus4(w_pcplus4), .instr(w_instr), .opc(w_opc),
      .f3(w_f3), .f7(w_f7), .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .instr_valid(w_valid), .err(w_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle before sampling/driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // complete a zero-wait fetch from FETCH into EXEC
   task automatic do_fetch(input logic [31:0] word);
      imem_rdy   = 1'b1;
      imem_rdata = word;
      step();
      imem_rdy   = 1'b0;
   endtask

   task automatic do_commit(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] alu);
      commit    = 1'b1;
      pcsrc     = sel;
      immext    = imm;
      aluresult = alu;
      step();
      commit    = 1'b0;
      pcsrc     = 2'b00;
      immext    = 32'h0;
      aluresult = 32'h0;
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst        = 1'b1;
      pcsrc      = 2'b00;
      immext     = 32'h0;
      aluresult  = 32'h0;
      commit     = 1'b0;
      imem_rdy   = 1'b0;
      imem_rdata = 32'h0;
      w_rst      = 1'b1;
      w_commit   = 1'b0;
      w_rdy      = 1'b0;

      step();
      step();
      check("rst_pc",    pc,          32'h0);
      check("rst_req",   imem_req,    32'h0);
      check("rst_instr", instr,       32'h0);
      check("rst_err",   err,         32'h0);
      check("rst_valid", instr_valid, 32'h0);

      rst = 1'b0;
      #1;
      check("first_req", imem_req, 32'h1);

      // sequential fetch, two cycles per instruction
      for (int k = 0; k < 4; k++) begin
         check("seq_req",  imem_req,  32'h1);
         check("seq_addr", imem_addr, 32'(k * 4));
         do_fetch(32'h0000_0013 + 32'(k << 7));
         check("seq_valid", instr_valid, 32'h1);
         check("seq_req_lo", imem_req, 32'h0);
         check("seq_instr", instr, 32'h0000_0013 + 32'(k << 7));
         check("seq_pcplus4", pcplus4, 32'(k * 4 + 4));
         do_commit(2'b00, 32'h0, 32'h0);
      end
      check("seq_pc_end", pc, 32'h10);

      // three wait states then data
      for (int k = 0; k < 3; k++) begin
         check("ws_req",  imem_req,  32'h1);
         check("ws_addr", imem_addr, 32'h10);
         step();
         check("ws_valid_lo", instr_valid, 32'h0);
      end
      check("ws_req4",  imem_req,  32'h1);
      check("ws_addr4", imem_addr, 32'h10);
      do_fetch(32'h00A3_0233);
      check("ws_valid", instr_valid, 32'h1);
      check("dec_opc", 32'(opc), 32'd51);
      check("dec_f3",  32'(f3),  32'd0);
      check("dec_f7",  32'(f7),  32'd0);
      check("dec_rd",  32'(rd),  32'd4);
      check("dec_rs1", 32'(rs1), 32'd6);
      check("dec_rs2", 32'(rs2), 32'd10);

      // spurious ready in EXEC must not reload instr
      imem_rdy   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_rdy   = 1'b0;
      check("spur_rdy_instr", instr, 32'h00A3_0233);
      check("spur_rdy_valid", instr_valid, 32'h1);

      do_commit(2'b01, 32'h30, 32'h0);
      check("br_fwd_pc", pc, 32'h40);

      // spurious commit in FETCH must not move pc
      commit = 1'b1;
      pcsrc  = 2'b01;
      immext = 32'h100;
      step();
      commit = 1'b0;
      check("spur_cmt_pc",  pc,       32'h40);
      check("spur_cmt_req", imem_req, 32'h1);

      do_fetch(32'h0000_0063);
      do_commit(2'b01, 32'hFFFF_FFF8, 32'h0);
      check("br_back_pc", pc, 32'h38);

      do_fetch(32'h0000_0067);
      do_commit(2'b10, 32'h0, 32'h101);
      check("jalr_pc", pc, 32'h100);

      do_fetch(32'h0000_0013);
      do_commit(2'b11, 32'h40, 32'h0);
      check("rsvd_pc", pc, 32'h104);

      do_fetch(32'h0000_0067);
      do_commit(2'b10, 32'h0, 32'h10);
      check("jalr2_pc", pc, 32'h10);

      // misaligned branch target traps
      do_fetch(32'h0000_0063);
      do_commit(2'b01, 32'h6, 32'h0);
      check("trap_err",   err,         32'h1);
      check("trap_pc",    pc,          32'h10);
      check("trap_req",   imem_req,    32'h0);
      check("trap_valid", instr_valid, 32'h0);
      imem_rdy = 1'b1;
      commit   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("trap_hold_err", err,      32'h1);
         check("trap_hold_req", imem_req, 32'h0);
         check("trap_hold_pc",  pc,       32'h10);
      end
      imem_rdy = 1'b0;
      commit   = 1'b0;

      rst = 1'b1;
      step();
      check("trap_rst_err", err, 32'h0);
      check("trap_rst_pc",  pc,  32'h0);
      rst = 1'b0;
      #1;
      check("trap_rst_req", imem_req, 32'h1);

      // reset coinciding with returned data discards it
      do_fetch(32'h1111_1113);
      check("pre_abort_instr", instr, 32'h1111_1113);
      do_commit(2'b00, 32'h0, 32'h0);
      check("pre_abort_pc", pc, 32'h4);
      rst        = 1'b1;
      imem_rdy   = 1'b1;
      imem_rdata = 32'h1234_5678;
      step();
      rst      = 1'b0;
      imem_rdy = 1'b0;
      check("abort_instr", instr,       32'h0);
      check("abort_valid", instr_valid, 32'h0);
      check("abort_pc",    pc,          32'h0);

      // wrap-around from the top of the address space
      w_rst = 1'b0;
      #1;
      check("wrap_addr0",   w_addr,    32'hFFFF_FFFC);
      check("wrap_pcplus4", w_pcplus4, 32'h0);
      w_rdy = 1'b1;
      step();
      w_rdy    = 1'b0;
      w_commit = 1'b1;
      step();
      w_commit = 1'b0;
      check("wrap_addr1", w_addr, 32'h0);
      check("wrap_req",   w_req,  32'h1);
      check("wrap_err",   w_err,  32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
